// File: rtl/fcta_pkg.sv
// ---------------------------------------------------------------------------
// fcta_pkg
//  Shared constants for the FCTA command sequencer slice: field widths of
//  the packed command beat, DataMover status bit positions, the sequencer
//  FSM state encodings and a helper that extracts the error bits of a
//  status word in err_flags order.
// ---------------------------------------------------------------------------
package fcta_pkg;

   localparam int CFG_BW           = 96;
   localparam int AXI_DM_CMD_WIDTH = 72;
   localparam int AXI_DM_STS_WIDTH = 8;

   // One command beat is {cfg, s2mm_cmd, mm2s_cmd}
   localparam int CMD_W = CFG_BW + 2 * AXI_DM_CMD_WIDTH;

   // DataMover status bit positions
   localparam int STS_OKAY   = 7;
   localparam int STS_SLVERR = 6;
   localparam int STS_DECERR = 5;
   localparam int STS_INTERR = 4;

   // Sequencer FSM encodings
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_FETCH = 3'd1;
   localparam state_t ST_WAIT  = 3'd2;
   localparam state_t ST_ISSUE = 3'd3;
   localparam state_t ST_DRAIN = 3'd4;
   localparam state_t ST_DONE  = 3'd5;

   // Error bits of one status word, ordered {INTERR, DECERR, SLVERR} to line
   // up with err_flags[2:0]
   function automatic logic [2:0] sts_err_bits(input logic [AXI_DM_STS_WIDTH-1:0] sts);
      return {sts[STS_INTERR], sts[STS_DECERR], sts[STS_SLVERR]};
   endfunction

endpackage

// File: rtl/fcta_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// fcta_cmd_sequencer_if
//  Stream bundle between the sequencer and the command splitter/DataMover.
//    m_axis_cmd_*       packed command beat {cfg, s2mm_cmd, mm2s_cmd}
//    s_axis_mm2s_sts_*  MM2S DataMover status stream
//    s_axis_s2mm_sts_*  S2MM DataMover status stream
//  master: the sequencer side; slave: the downstream side.
// ---------------------------------------------------------------------------
interface fcta_cmd_sequencer_if;
   import fcta_pkg::*;

   logic                        m_axis_cmd_tvalid;
   logic [CMD_W-1:0]            m_axis_cmd_tdata;
   logic                        m_axis_cmd_tready;

   logic                        s_axis_mm2s_sts_tvalid;
   logic                        s_axis_mm2s_sts_tlast;
   logic [AXI_DM_STS_WIDTH-1:0] s_axis_mm2s_sts_tdata;
   logic                        s_axis_mm2s_sts_tready;

   logic                        s_axis_s2mm_sts_tvalid;
   logic                        s_axis_s2mm_sts_tlast;
   logic [AXI_DM_STS_WIDTH-1:0] s_axis_s2mm_sts_tdata;
   logic                        s_axis_s2mm_sts_tready;

   modport master (
      output m_axis_cmd_tvalid, m_axis_cmd_tdata,
      input  m_axis_cmd_tready,
      input  s_axis_mm2s_sts_tvalid, s_axis_mm2s_sts_tlast, s_axis_mm2s_sts_tdata,
      output s_axis_mm2s_sts_tready,
      input  s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tlast, s_axis_s2mm_sts_tdata,
      output s_axis_s2mm_sts_tready
   );

   modport slave (
      input  m_axis_cmd_tvalid, m_axis_cmd_tdata,
      output m_axis_cmd_tready,
      output s_axis_mm2s_sts_tvalid, s_axis_mm2s_sts_tlast, s_axis_mm2s_sts_tdata,
      input  s_axis_mm2s_sts_tready,
      output s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tlast, s_axis_s2mm_sts_tdata,
      input  s_axis_s2mm_sts_tready
   );

endinterface

// File: rtl/fcta_outst_cnt.sv
// ---------------------------------------------------------------------------
// fcta_outst_cnt
//  In-flight command counter for one DataMover channel.
//  Ports:
//    clk, rstn   clock, async active-low reset
//    inc         command accepted downstream on this channel
//    dec         status accepted on this channel
//    zero        nothing in flight
//    full_next   count after this cycle's update equals MAX
//    underflow   a status arrived while nothing was in flight
// ---------------------------------------------------------------------------
module fcta_outst_cnt #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic inc,
   input  logic dec,
   output logic zero,
   output logic full_next,
   output logic underflow
);

   logic [3:0] count;
   logic [3:0] count_nxt;

   // A simultaneous command and status cancel out; a status with nothing in
   // flight leaves the count at zero and is reported as underflow instead.
   always_comb begin
      count_nxt = count;
      if (inc && !dec) begin
         count_nxt = count + 4'd1;
      end else if (dec && !inc && (count != 4'd0)) begin
         count_nxt = count - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= 4'd0;
      end else begin
         count <= count_nxt;
      end
   end

   assign zero      = (count == 4'd0);
   assign full_next = (count_nxt == 4'(MAX));
   assign underflow = dec && zero;

endmodule

// File: rtl/fcta_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// fcta_cmd_sequencer
//  Walks a descriptor list in the FCTA control BRAM, one 256-bit word per
//  descriptor, and issues each as one beat on the packed command stream.
//  In-flight commands are bounded per DataMover channel; both status
//  streams are collected and completion/errors reported to the register file.
//  Ports:
//    clk, rstn            clock, async active-low reset
//    start                1-cycle pulse, begins a list when idle
//    base_addr            byte address of descriptor 0
//    num_desc             descriptor count, sampled on start
//    busy, done           list in progress / 1-cycle completion pulse
//    err_flags            sticky {unexpected, INTERR, DECERR, SLVERR}
//    issued_cnt, sts_cnt  commands accepted / S2MM statuses received
//    bram_*               BRAM port B, read only, 1-cycle latency
//    axis                 command and status streams (master side)
// ---------------------------------------------------------------------------
module fcta_cmd_sequencer
   import fcta_pkg::*;
#(
   parameter int C_BRAM_ADDR_WIDTH = 32,
   parameter int C_BRAM_DATA_WIDTH = 256,
   parameter int CNT_BW            = 16,
   parameter int MAX_OUTST         = 4
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           start,
   input  logic [C_BRAM_ADDR_WIDTH-1:0]   base_addr,
   input  logic [CNT_BW-1:0]              num_desc,
   output logic                           busy,
   output logic                           done,
   output logic [3:0]                     err_flags,
   output logic [CNT_BW-1:0]              issued_cnt,
   output logic [CNT_BW-1:0]              sts_cnt,
   output logic                           bram_clkb,
   output logic                           bram_rstb,
   output logic [C_BRAM_ADDR_WIDTH-1:0]   bram_addrb,
   output logic                           bram_enb,
   output logic [C_BRAM_DATA_WIDTH/8-1:0] bram_web,
   output logic [C_BRAM_DATA_WIDTH-1:0]   bram_dinb,
   input  logic [C_BRAM_DATA_WIDTH-1:0]   bram_doutb,
   fcta_cmd_sequencer_if.master           axis
);

   localparam logic [C_BRAM_ADDR_WIDTH-1:0] WORD_BYTES = C_BRAM_ADDR_WIDTH'(C_BRAM_DATA_WIDTH / 8);

   state_t                         state;
   state_t                         state_nxt;
   logic                           have_cmd;
   logic [CNT_BW-1:0]              idx;
   logic [CNT_BW-1:0]              idx_inc;
   logic [CNT_BW-1:0]              num_reg;
   logic [C_BRAM_ADDR_WIDTH-1:0]   base_reg;
   logic [CMD_W-1:0]               tdata_reg;
   logic                           sts_ready;

   logic                           accept;
   logic                           cmd_hs;
   logic                           mm2s_hs;
   logic                           s2mm_hs;
   logic                           more_desc;
   logic                           gate_closed;
   logic                           mm2s_zero;
   logic                           s2mm_zero;
   logic                           mm2s_full_next;
   logic                           s2mm_full_next;
   logic                           mm2s_under;
   logic                           s2mm_under;
   logic [3:0]                     err_new;
   logic                           unused_inputs;

   assign accept  = (state == ST_IDLE) && start;
   assign cmd_hs  = axis.m_axis_cmd_tvalid && axis.m_axis_cmd_tready;
   assign mm2s_hs = axis.s_axis_mm2s_sts_tvalid && sts_ready;
   assign s2mm_hs = axis.s_axis_s2mm_sts_tvalid && sts_ready;

   assign idx_inc     = idx + 1'b1;
   assign more_desc   = (idx_inc < num_reg);
   assign gate_closed = mm2s_full_next || s2mm_full_next;

   fcta_outst_cnt #(.MAX(MAX_OUTST)) u_outst_mm2s (
      .clk       (clk),
      .rstn      (rstn),
      .inc       (cmd_hs),
      .dec       (mm2s_hs),
      .zero      (mm2s_zero),
      .full_next (mm2s_full_next),
      .underflow (mm2s_under)
   );

   fcta_outst_cnt #(.MAX(MAX_OUTST)) u_outst_s2mm (
      .clk       (clk),
      .rstn      (rstn),
      .inc       (cmd_hs),
      .dec       (s2mm_hs),
      .zero      (s2mm_zero),
      .full_next (s2mm_full_next),
      .underflow (s2mm_under)
   );

   // ISSUE doubles as the outstanding-limit wait: once the beat has been
   // accepted have_cmd drops and the FSM sits here until both channels have
   // room, so the next fetch can never push a counter past MAX_OUTST.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (num_desc == '0) ? ST_DRAIN : ST_FETCH;
            end
         end
         ST_FETCH: state_nxt = ST_WAIT;
         ST_WAIT:  state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            if (have_cmd) begin
               if (cmd_hs) begin
                  if (!more_desc) begin
                     state_nxt = ST_DRAIN;
                  end else if (!gate_closed) begin
                     state_nxt = ST_FETCH;
                  end
               end
            end else if (!gate_closed) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (mm2s_zero && s2mm_zero) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Status errors from either channel plus unexpected statuses; these are
   // OR'd into the sticky flags even when no list is running.
   always_comb begin
      err_new = 4'd0;
      if (mm2s_hs) begin
         err_new[2:0] = err_new[2:0] | sts_err_bits(axis.s_axis_mm2s_sts_tdata);
      end
      if (s2mm_hs) begin
         err_new[2:0] = err_new[2:0] | sts_err_bits(axis.s_axis_s2mm_sts_tdata);
      end
      err_new[3] = mm2s_under || s2mm_under;
   end

   // List bookkeeping; the flag/counter clear on start still merges any
   // status that lands in the same cycle so it is not lost.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         have_cmd   <= 1'b0;
         idx        <= '0;
         num_reg    <= '0;
         base_reg   <= '0;
         tdata_reg  <= '0;
         sts_ready  <= 1'b0;
         issued_cnt <= '0;
         sts_cnt    <= '0;
         err_flags  <= 4'd0;
      end else begin
         state     <= state_nxt;
         sts_ready <= 1'b1;

         if (accept) begin
            base_reg <= base_addr;
            num_reg  <= num_desc;
            idx      <= '0;
         end else if (cmd_hs) begin
            idx <= idx_inc;
         end

         if (state == ST_WAIT) begin
            tdata_reg <= bram_doutb[CMD_W-1:0];
            have_cmd  <= 1'b1;
         end else if (cmd_hs) begin
            have_cmd <= 1'b0;
         end

         if (accept) begin
            issued_cnt <= '0;
         end else if (cmd_hs) begin
            issued_cnt <= issued_cnt + 1'b1;
         end

         sts_cnt   <= (accept ? '0 : sts_cnt) + CNT_BW'(s2mm_hs);
         err_flags <= (accept ? 4'd0 : err_flags) | err_new;
      end
   end

   assign busy = (state != ST_IDLE) && (state != ST_DONE);
   assign done = (state == ST_DONE);

   assign bram_clkb  = clk;
   assign bram_rstb  = ~rstn;
   assign bram_enb   = (state == ST_FETCH);
   assign bram_addrb = bram_enb ? (base_reg + C_BRAM_ADDR_WIDTH'(idx) * WORD_BYTES) : '0;
   assign bram_web   = '0;
   assign bram_dinb  = '0;

   assign axis.m_axis_cmd_tvalid      = (state == ST_ISSUE) && have_cmd;
   assign axis.m_axis_cmd_tdata       = tdata_reg;
   assign axis.s_axis_mm2s_sts_tready = sts_ready;
   assign axis.s_axis_s2mm_sts_tready = sts_ready;

   // Bits that carry no information for the sequencer
   assign unused_inputs = ^{bram_doutb[C_BRAM_DATA_WIDTH-1:CMD_W],
                            axis.s_axis_mm2s_sts_tlast, axis.s_axis_s2mm_sts_tlast,
                            axis.s_axis_mm2s_sts_tdata[STS_OKAY], axis.s_axis_mm2s_sts_tdata[3:0],
                            axis.s_axis_s2mm_sts_tdata[STS_OKAY], axis.s_axis_s2mm_sts_tdata[3:0]};

endmodule

// File: tb/tb_fcta_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fcta_cmd_sequencer
//  Directed bench for the FCTA command sequencer: a table of list runs plus
//  hand-written sequences for outstanding limit, back-pressure and reset.
// ---------------------------------------------------------------------------
module tb_fcta_cmd_sequencer;
   import fcta_pkg::*;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic [31:0]   base_addr;
   logic [15:0]   num_desc;
   logic          busy;
   logic          done;
   logic [3:0]    err_flags;
   logic [15:0]   issued_cnt;
   logic [15:0]   sts_cnt;
   logic          bram_clkb;
   logic          bram_rstb;
   logic [31:0]   bram_addrb;
   logic          bram_enb;
   logic [31:0]   bram_web;
   logic [255:0]  bram_dinb;
   logic [255:0]  bram_doutb = '0;

   fcta_cmd_sequencer_if ifc ();

   fcta_cmd_sequencer #(
      .C_BRAM_ADDR_WIDTH (32),
      .C_BRAM_DATA_WIDTH (256),
      .CNT_BW            (16),
      .MAX_OUTST         (4)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .base_addr  (base_addr),
      .num_desc   (num_desc),
      .busy       (busy),
      .done       (done),
      .err_flags  (err_flags),
      .issued_cnt (issued_cnt),
      .sts_cnt    (sts_cnt),
      .bram_clkb  (bram_clkb),
      .bram_rstb  (bram_rstb),
      .bram_addrb (bram_addrb),
      .bram_enb   (bram_enb),
      .bram_web   (bram_web),
      .bram_dinb  (bram_dinb),
      .bram_doutb (bram_doutb),
      .axis       (ifc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Observation logs filled on the rising edge
   int               cyc      = 0;
   int               done_cnt = 0;
   int               enb_cnt  = 0;
   int               beats    = 0;
   logic [31:0]      addr_log [0:127];
   logic [CMD_W-1:0] beat_log [0:127];

   // Status responder state
   bit auto_sts = 1'b1;
   int err_beat = -1;
   int due_cyc [0:127];
   int due_wr = 0;
   int due_rd = 0;
   int req_m = 0;
   int ack_m = 0;
   int req_s = 0;
   int ack_s = 0;

   typedef struct {
      logic [31:0] base;
      logic [15:0] num;
      int          err_pos;
      logic [15:0] exp_issued;
      logic [15:0] exp_sts;
      logic [3:0]  exp_err;
   } vec_t;

   vec_t vecs [4];

   // Deterministic BRAM contents derived from the word address
   function automatic logic [255:0] bram_word(input logic [31:0] a);
      return {a ^ 32'h1111_1111, a + 32'h7, ~a, a ^ 32'hDEAD_BEEF,
              a + 32'h1234, {a[15:0], a[31:16]}, a ^ 32'h5A5A_5A5A, a};
   endfunction

   always @(posedge clk) begin
      if (bram_enb) begin
         bram_doutb <= bram_word(bram_addrb);
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
      end
      if (bram_enb) begin
         addr_log[enb_cnt] <= bram_addrb;
         enb_cnt           <= enb_cnt + 1;
      end
      if (ifc.m_axis_cmd_tvalid && ifc.m_axis_cmd_tready) begin
         beat_log[beats] <= ifc.m_axis_cmd_tdata;
         beats           <= beats + 1;
         if (auto_sts) begin
            due_cyc[due_wr] <= cyc + 5;
            due_wr          <= due_wr + 1;
         end
      end
   end

   // Statuses: automatic ones 5 cycles after each command, else on request
   always @(negedge clk) begin
      ifc.s_axis_mm2s_sts_tvalid <= 1'b0;
      ifc.s_axis_s2mm_sts_tvalid <= 1'b0;
      ifc.s_axis_mm2s_sts_tlast  <= 1'b1;
      ifc.s_axis_s2mm_sts_tlast  <= 1'b1;
      ifc.s_axis_mm2s_sts_tdata  <= 8'h80;
      ifc.s_axis_s2mm_sts_tdata  <= 8'h80;
      if (auto_sts && (due_rd < due_wr) && (due_cyc[due_rd] <= cyc)) begin
         ifc.s_axis_mm2s_sts_tvalid <= 1'b1;
         ifc.s_axis_s2mm_sts_tvalid <= 1'b1;
         ifc.s_axis_s2mm_sts_tdata  <= (due_rd == err_beat) ? 8'h20 : 8'h80;
         due_rd <= due_rd + 1;
      end else begin
         if (req_m > ack_m) begin
            ifc.s_axis_mm2s_sts_tvalid <= 1'b1;
            ack_m <= ack_m + 1;
         end
         if (req_s > ack_s) begin
            ifc.s_axis_s2mm_sts_tvalid <= 1'b1;
            ack_s <= ack_s + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic waitDone(input int d0, input int budget, input string name);
      int waited = 0;
      while ((done_cnt == d0) && (waited < budget)) begin
         @(negedge clk);
         waited++;
      end
      checkOutput(name, 256'(done_cnt != d0), 256'(1));
   endtask

   task automatic waitBeats(input int target, input int budget, input string name);
      int waited = 0;
      while ((beats < target) && (waited < budget)) begin
         @(negedge clk);
         waited++;
      end
      checkOutput(name, 256'(beats), 256'(target));
   endtask

   task automatic waitValid(input int budget, input string name);
      int waited = 0;
      while (!ifc.m_axis_cmd_tvalid && (waited < budget)) begin
         @(negedge clk);
         waited++;
      end
      checkOutput(name, 256'(ifc.m_axis_cmd_tvalid), 256'(1));
   endtask

   task automatic pulseStart(input logic [31:0] b, input logic [15:0] n);
      base_addr = b;
      num_desc  = n;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // One full list run from the table, with cycle-exact latency checks
   task automatic applyStimulus(input vec_t v);
      int b0 = beats;
      int e0 = enb_cnt;
      int d0 = done_cnt;
      logic [255:0] w;
      logic [31:0]  a;
      err_beat = (v.err_pos >= 0) ? (due_wr + v.err_pos) : -1;
      pulseStart(v.base, v.num);
      checkOutput("busy_c1", 256'(busy), 256'(1));
      checkOutput("err_clear_c1", 256'(err_flags), 256'(0));
      checkOutput("enb_c1", 256'(bram_enb), 256'(v.num != 0));
      @(negedge clk);
      checkOutput("done_c2", 256'(done), 256'(v.num == 0));
      @(negedge clk);
      if (v.num != 0) begin
         checkOutput("tvalid_c3", 256'(ifc.m_axis_cmd_tvalid), 256'(1));
      end
      waitDone(d0, 300, "list_done");
      repeat (10) @(negedge clk);
      checkOutput("done_once", 256'(done_cnt - d0), 256'(1));
      checkOutput("issued_cnt", 256'(issued_cnt), 256'(v.exp_issued));
      checkOutput("sts_cnt", 256'(sts_cnt), 256'(v.exp_sts));
      checkOutput("err_flags", 256'(err_flags), 256'(v.exp_err));
      checkOutput("beat_count", 256'(beats - b0), 256'(v.num));
      checkOutput("read_count", 256'(enb_cnt - e0), 256'(v.num));
      for (int i = 0; i < int'(v.num); i++) begin
         a = v.base + 32'(i) * 32'd32;
         w = bram_word(a);
         checkOutput("read_addr", 256'(addr_log[e0 + i]), 256'(a));
         checkOutput("beat_tdata", 256'(beat_log[b0 + i]), 256'(w[CMD_W-1:0]));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [255:0] w;
      logic [CMD_W-1:0] held;
      int b0;
      int d0;

      vecs[0] = '{base: 32'h0000_0040, num: 16'd3, err_pos: -1, exp_issued: 16'd3, exp_sts: 16'd3, exp_err: 4'b0000};
      vecs[1] = '{base: 32'h0000_0000, num: 16'd0, err_pos: -1, exp_issued: 16'd0, exp_sts: 16'd0, exp_err: 4'b0000};
      vecs[2] = '{base: 32'h0000_1000, num: 16'd4, err_pos:  1, exp_issued: 16'd4, exp_sts: 16'd4, exp_err: 4'b0010};
      vecs[3] = '{base: 32'hFFFF_FFE0, num: 16'd2, err_pos: -1, exp_issued: 16'd2, exp_sts: 16'd2, exp_err: 4'b0000};

      rstn      = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      num_desc  = '0;
      ifc.m_axis_cmd_tready = 1'b1;

      // Reset state
      #2;
      checkOutput("rst_busy", 256'(busy), 256'(0));
      checkOutput("rst_done", 256'(done), 256'(0));
      checkOutput("rst_err", 256'(err_flags), 256'(0));
      checkOutput("rst_issued", 256'(issued_cnt), 256'(0));
      checkOutput("rst_tvalid", 256'(ifc.m_axis_cmd_tvalid), 256'(0));
      checkOutput("rst_enb", 256'(bram_enb), 256'(0));
      checkOutput("rst_bram_rstb", 256'(bram_rstb), 256'(1));
      checkOutput("rst_sts_tready", 256'(ifc.s_axis_mm2s_sts_tready), 256'(0));
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checkOutput("rel_bram_rstb", 256'(bram_rstb), 256'(0));
      checkOutput("rel_sts_tready", 256'(ifc.s_axis_s2mm_sts_tready), 256'(1));

      // Table-driven list runs
      for (int k = 0; k < 4; k++) begin
         applyStimulus(vecs[k]);
      end

      // Outstanding limit: statuses withheld, four beats then stall
      auto_sts = 1'b0;
      b0 = beats;
      d0 = done_cnt;
      pulseStart(32'h0000_0200, 16'd8);
      repeat (40) @(negedge clk);
      checkOutput("stall_beats", 256'(beats - b0), 256'(4));
      checkOutput("stall_issued", 256'(issued_cnt), 256'(4));
      checkOutput("stall_tvalid", 256'(ifc.m_axis_cmd_tvalid), 256'(0));
      req_m++;
      req_s++;
      waitBeats(b0 + 5, 20, "release_beat5");
      repeat (10) @(negedge clk);
      checkOutput("restall_beats", 256'(beats - b0), 256'(5));
      for (int k = 0; k < 7; k++) begin
         req_m++;
         req_s++;
         repeat (5) @(negedge clk);
      end
      waitDone(d0, 100, "limit_done");
      repeat (3) @(negedge clk);
      checkOutput("limit_issued", 256'(issued_cnt), 256'(8));
      checkOutput("limit_sts", 256'(sts_cnt), 256'(8));
      checkOutput("limit_err", 256'(err_flags), 256'(0));

      // Back-pressure: tready low for 10 cycles while a beat is pending
      auto_sts = 1'b1;
      ifc.m_axis_cmd_tready = 1'b0;
      d0 = done_cnt;
      w = bram_word(32'h0000_0300);
      held = w[CMD_W-1:0];
      pulseStart(32'h0000_0300, 16'd1);
      waitValid(20, "bp_tvalid_up");
      for (int k = 0; k < 10; k++) begin
         checkOutput("bp_tvalid_held", 256'(ifc.m_axis_cmd_tvalid), 256'(1));
         checkOutput("bp_tdata_stable", 256'(ifc.m_axis_cmd_tdata), 256'(held));
         @(negedge clk);
      end
      checkOutput("bp_issued_before", 256'(issued_cnt), 256'(0));
      ifc.m_axis_cmd_tready = 1'b1;
      @(negedge clk);
      checkOutput("bp_issued_after", 256'(issued_cnt), 256'(1));
      waitDone(d0, 50, "bp_done");
      checkOutput("bp_issued_final", 256'(issued_cnt), 256'(1));

      // Reset in the middle of ISSUE, then a stray MM2S status
      auto_sts = 1'b0;
      ifc.m_axis_cmd_tready = 1'b0;
      pulseStart(32'h0000_0400, 16'd2);
      waitValid(20, "mid_tvalid_up");
      rstn = 1'b0;
      #1;
      checkOutput("mid_rst_tvalid", 256'(ifc.m_axis_cmd_tvalid), 256'(0));
      checkOutput("mid_rst_busy", 256'(busy), 256'(0));
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checkOutput("mid_rel_sts_tready", 256'(ifc.s_axis_mm2s_sts_tready), 256'(1));
      checkOutput("mid_rel_err", 256'(err_flags), 256'(0));
      req_m++;
      repeat (3) @(negedge clk);
      checkOutput("stray_sts_err", 256'(err_flags), 256'(4'b1000));

      // Command handshake and MM2S status in the same cycle with the
      // counter at zero: counter stays 0, so one later status drains it
      b0 = beats;
      d0 = done_cnt;
      pulseStart(32'h0000_0500, 16'd2);
      checkOutput("same_err_clear", 256'(err_flags), 256'(0));
      waitValid(20, "same_tvalid_up");
      @(posedge clk);
      #1;
      req_m++;
      @(negedge clk);
      ifc.m_axis_cmd_tready = 1'b1;
      @(negedge clk);
      checkOutput("same_issued", 256'(issued_cnt), 256'(1));
      waitBeats(b0 + 2, 20, "same_beat2");
      req_m++;
      req_s += 2;
      waitDone(d0, 60, "same_done");
      checkOutput("same_err", 256'(err_flags), 256'(4'b1000));
      checkOutput("same_issued_final", 256'(issued_cnt), 256'(2));
      checkOutput("same_sts_cnt", 256'(sts_cnt), 256'(2));

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
